// File: rtl/des_expand_xor_pipe.sv
// Pipelined DES E-box: expands a 4*GROUPS-bit half-block to 6*GROUPS bits with
// the wrap-around neighbour rule, optionally keys it, and streams it out.
module des_expand_xor_pipe #(
   parameter int GROUPS = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic                  wClk,
   input  logic                  wReset,
   input  logic                  wInValid,
   output logic                  rInReady,
   input  logic [4*GROUPS-1:0]   wInData,
   input  logic [6*GROUPS-1:0]   wSubKey,
   input  logic                  wXorEn,
   output logic                  rOutValid,
   input  logic                  wOutReady,
   output logic [6*GROUPS-1:0]   rOutData,
   output logic [CNT_W-1:0]      rXferCount
);

   localparam int N = 4 * GROUPS;
   localparam int M = 6 * GROUPS;

   logic [M-1:0]      expanded;
   logic [M-1:0]      keyed;
   logic [STAGES-1:0] load;
   logic [STAGES-1:0] drain;
   logic [STAGES-1:0] v_q, v_d;
   logic [M-1:0]      d_q [STAGES];
   logic [M-1:0]      d_d [STAGES];
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // DES bit k (1 = MSB) lives at vector index N-k; group edges borrow the
   // neighbouring groups' outer bits, wrapping around the half-block.
   for (genvar g = 0; g < GROUPS; g++) begin : g_expand
      localparam int FIRST = (g == 0)          ? 0     : N - 4*g;
      localparam int LAST  = (g == GROUPS - 1) ? N - 1 : N - 4*g - 5;
      assign expanded[M-1-6*g]      = wInData[FIRST];
      assign expanded[M-2-6*g -: 4] = wInData[N-1-4*g -: 4];
      assign expanded[M-6-6*g]      = wInData[LAST];
   end

   assign keyed = expanded ^ (wXorEn ? wSubKey : '0);

   // Ready ripples backwards: a stage may load if empty or draining now.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      drain = '0;
      load  = '0;
      drain[STAGES-1] = v_q[STAGES-1] & wOutReady;
      load[STAGES-1]  = ~v_q[STAGES-1] | drain[STAGES-1];
      for (int i = STAGES - 2; i >= 0; i--) begin
         drain[i] = v_q[i] & load[i+1];
         load[i]  = ~v_q[i] | drain[i];
      end
   end

   always_comb begin
      v_d = v_q;
      for (int i = 0; i < STAGES; i++) begin
         d_d[i] = d_q[i];
      end
      if (load[0]) begin
         v_d[0] = wInValid;
         if (wInValid) begin
            d_d[0] = keyed;
         end
      end
      for (int i = 1; i < STAGES; i++) begin
         if (load[i]) begin
            v_d[i] = v_q[i-1];
            if (v_q[i-1]) begin
               d_d[i] = d_q[i-1];
            end
         end
      end
      cnt_d = cnt_q + CNT_W'(drain[STAGES-1]);
   end

   always_ff @(posedge wClk or posedge wReset) begin
      if (wReset) begin
         v_q   <= '0;
         cnt_q <= '0;
         // NOTE: the data registers are reset too, so rOutData reads 0 straight out of reset.
         for (int i = 0; i < STAGES; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         // NOTE: state updates use <= so every stage samples the pre-edge values of its neighbour.
         v_q   <= v_d;
         cnt_q <= cnt_d;
         for (int i = 0; i < STAGES; i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

   assign rInReady   = load[0];
   assign rOutValid  = v_q[STAGES-1];
   assign rOutData   = d_q[STAGES-1];
   assign rXferCount = cnt_q;

endmodule

// File: tb/tb_des_expand_xor_pipe.sv
// Scoreboard bench for des_expand_xor_pipe: the driver tags each accepted word
// with its expected result and a negedge monitor checks outputs in order.
module tb_des_expand_xor_pipe;

   localparam int G  = 8;
   localparam int ST = 2;
   localparam int N  = 4 * G;
   localparam int M  = 6 * G;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [N-1:0]  in_data;
   logic [M-1:0]  sub_key;
   logic          xor_en;
   logic          out_ready;
   logic          in_ready, out_valid;
   logic [M-1:0]  out_data;
   logic [15:0]   count;
   logic          in_ready4, out_valid4;
   logic [M-1:0]  out_data4;
   logic [3:0]    count4;

   logic [M-1:0]  exp_q [$];
   logic [M-1:0]  cur_exp;
   int            model_cnt;
   int            n_checks;
   int            n_errors;
   bit            prev_stall;
   logic [M-1:0]  prev_data;
   bit            ready_mode;
   bit            ready_fixed;

   des_expand_xor_pipe #(.GROUPS(G), .STAGES(ST), .CNT_W(16)) dut (
      .wClk(clk), .wReset(rst), .wInValid(in_valid), .rInReady(in_ready),
      .wInData(in_data), .wSubKey(sub_key), .wXorEn(xor_en),
      .rOutValid(out_valid), .wOutReady(out_ready), .rOutData(out_data),
      .rXferCount(count)
   );

   des_expand_xor_pipe #(.GROUPS(G), .STAGES(ST), .CNT_W(4)) dut_w4 (
      .wClk(clk), .wReset(rst), .wInValid(in_valid), .rInReady(in_ready4),
      .wInData(in_data), .wSubKey(sub_key), .wXorEn(xor_en),
      .rOutValid(out_valid4), .wOutReady(out_ready), .rOutData(out_data4),
      .rXferCount(count4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: output bit j (1 = MSB) copies input bit ((j-1)/6)*4 + (j-1)%6,
   // with 0 standing for N and N+1 standing for 1.
   function automatic logic [M-1:0] expand_model(input logic [N-1:0] d,
                                                 input logic [M-1:0] k,
                                                 input logic xe);
      logic [M-1:0] e;
      int src;
      for (int j = 1; j <= M; j++) begin
         src = ((j - 1) / 6) * 4 + ((j - 1) % 6);
         if (src == 0) src = N;
         else if (src == N + 1) src = 1;
         e[M-j] = d[N-src];
      end
      return xe ? (e ^ k) : e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s", name);
   endtask

   // Monitor: pushes on input handshakes, pops and compares on output handshakes.
   always @(negedge clk) begin
      logic [M-1:0] e;
      if (rst) begin
         exp_q.delete();
         model_cnt  = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(out_data), 64'(prev_data));
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            check("w4_in_ready", 64'(in_ready4), 64'd1);
         end
         if (out_valid && out_ready) begin
            check("xfer_count", 64'(count), 64'(model_cnt[15:0]));
            check("xfer_count_w4", 64'(count4), 64'(model_cnt[3:0]));
            check("w4_valid", 64'(out_valid4), 64'd1);
            if (exp_q.size() == 0) begin
               fail("spurious_output");
            end else begin
               e = exp_q.pop_front();
               check("out_data", 64'(out_data), 64'(e));
               check("w4_data", 64'(out_data4), 64'(e));
            end
            model_cnt++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Holds a word on the input until accepted; returns cycles spent.
   task automatic send(input logic [N-1:0] d, input logic [M-1:0] k, input logic xe,
                       input logic [M-1:0] e, output int waited);
      bit hs;
      hs = 1'b0;
      waited = 0;
      in_valid = 1'b1;
      in_data  = d;
      sub_key  = k;
      xor_en   = xe;
      cur_exp  = e;
      while (!hs && waited < 50) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      if (!hs) fail("input_accept_timeout");
   endtask

   task automatic send_rand(output int waited);
      logic [N-1:0] d;
      logic [M-1:0] k;
      logic         xe;
      d  = $urandom;
      k  = {16'($urandom), 32'($urandom)};
      xe = 1'($urandom_range(0, 1));
      send(d, k, xe, expand_model(d, k, xe), waited);
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 1000) begin
         @(posedge clk);
         c++;
      end
      if (exp_q.size() != 0) fail("drain_timeout");
      idle(1);
   endtask

   // Single word with an independent expected constant plus a latency check.
   task automatic directed(input string name, input logic [N-1:0] d, input logic [M-1:0] k,
                           input logic xe, input logic [M-1:0] e);
      int w, cycles;
      bit seen;
      send(d, k, xe, e, w);
      in_valid = 1'b0;
      cycles = 0;
      seen = 1'b0;
      while (!seen && cycles < 10) begin
         @(negedge clk);
         cycles++;
         seen = out_valid;
      end
      check(name, 64'(cycles), 64'(ST));
      idle(2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog_expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, total, acc;
      bit hs;
      logic [N-1:0] bw [5];
      logic [M-1:0] bk [5];
      logic         bx [5];

      n_checks = 0;
      n_errors = 0;
      in_valid = 1'b0;
      in_data = '0;
      sub_key = '0;
      xor_en = 1'b0;
      cur_exp = '0;
      ready_mode = 1'b0;
      ready_fixed = 1'b1;
      rst = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_data", 64'(out_data), 64'd0);
      check("reset_count", 64'(count), 64'd0);
      #2 rst = 1'b0;
      #1 check("ready_after_reset", 64'(in_ready), 64'd1);
      idle(2);

      directed("fips_latency", 32'hF0AAF0AA, '0, 1'b0, 48'h7A15557A1555);
      check("fips_count", 64'(count), 64'd1);
      directed("xor_latency", 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1, 48'h6117BA866527);
      directed("wrap_latency", 32'h80000001, '0, 1'b0, 48'hC00000000003);
      check("count_after_directed", 64'(count), 64'd3);

      // Backpressure: only STAGES words fit while the output is blocked.
      reset_pulse();
      ready_fixed = 1'b0;
      idle(2);
      for (int i = 0; i < 5; i++) begin
         bw[i] = $urandom;
         bk[i] = {16'($urandom), 32'($urandom)};
         bx[i] = 1'($urandom_range(0, 1));
      end
      acc = 0;
      in_valid = 1'b1;
      in_data = bw[0];
      sub_key = bk[0];
      xor_en = bx[0];
      cur_exp = expand_model(bw[0], bk[0], bx[0]);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            acc++;
            if (acc < 5) begin
               in_data = bw[acc];
               sub_key = bk[acc];
               xor_en = bx[acc];
               cur_exp = expand_model(bw[acc], bk[acc], bx[acc]);
            end
         end
      end
      check("bp_accepts", 64'(acc), 64'(ST));
      @(negedge clk);
      check("bp_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      ready_fixed = 1'b1;
      for (int i = acc; i < 5; i++) begin
         send(bw[i], bk[i], bx[i], expand_model(bw[i], bk[i], bx[i]), w);
      end
      in_valid = 1'b0;
      drain();
      check("bp_count", 64'(count), 64'd5);

      // Full throughput: 100 words in 100 cycles with the output always ready.
      total = 0;
      for (int i = 0; i < 100; i++) begin
         send_rand(w);
         total += w;
      end
      in_valid = 1'b0;
      check("throughput_cycles", 64'(total), 64'd100);
      drain();

      // Random downstream stalls.
      ready_mode = 1'b1;
      for (int i = 0; i < 100; i++) begin
         send_rand(w);
      end
      in_valid = 1'b0;
      drain();
      ready_mode = 1'b0;
      ready_fixed = 1'b0;
      idle(2);

      // Reset with two words in flight.
      send_rand(w);
      send_rand(w);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midreset_valid", 64'(out_valid), 64'd0);
      check("midreset_data", 64'(out_data), 64'd0);
      check("midreset_count", 64'(count), 64'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      ready_fixed = 1'b1;
      idle(2);
      directed("post_reset_latency", 32'h12345678, 48'hA5A5A5A5A5A5, 1'b1,
               expand_model(32'h12345678, 48'hA5A5A5A5A5A5, 1'b1));
      check("post_reset_count", 64'(count), 64'd1);

      // Counter wrap on the 4-bit instance.
      reset_pulse();
      for (int i = 0; i < 17; i++) begin
         send_rand(w);
      end
      in_valid = 1'b0;
      drain();
      check("wrap_count_w4", 64'(count4), 64'd1);
      check("wrap_count_w16", 64'(count), 64'd17);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/des_expand_xor_pipe.md
Name: des_expand_xor_pipe

Overview:
Parametrised, pipelined successor to the combinational DES E-box. Expands an N=4*GROUPS-bit Feistel half-block to 6*GROUPS bits using the DES wrap-around neighbour rule. Optionally XORs the result with a round subkey. Sits between the round register and the S-box stage, with valid/ready flow control and a configurable register depth.

Parameters:
GROUPS, 8, number of 4-bit input groups; N=4*GROUPS input bits, M=6*GROUPS output bits; legal range 2..16
STAGES, 2, pipeline register depth; legal range 1..4
CNT_W, 16, width of the output transfer counter

Ports:
wClk  input  1  clock, all state rising-edge
wReset  input  1  asynchronous, active-high reset
wInValid  input  1  upstream data valid
rInReady  output  1  block accepts input this cycle
wInData  input  N  half-block; bit 1 (DES numbering) = MSB
wSubKey  input  M  round subkey, captured with wInData; bit 1 = MSB
wXorEn  input  1  1 = XOR subkey, 0 = plain expansion; captured with wInData
rOutValid  output  1  output data valid
wOutReady  input  1  downstream accepts output
rOutData  output  M  expanded (and optionally keyed) data; bit 1 = MSB
rXferCount  output  CNT_W  count of completed output handshakes

Behaviour:
- Expansion, DES numbering with 1 = MSB:
  - For group g=0..GROUPS-1: E[6g+1]=in[4g], E[6g+2..6g+5]=in[4g+1..4g+4], E[6g+6]=in[4g+5].
  - Wrap rule: in[0] means in[N]; in[N+1] means in[1].
  - GROUPS=8 gives exactly the FIPS 46-3 E table.
- Stage 1 registers E XOR (wXorEn ? wSubKey : 0). Stages 2..STAGES are plain register copies. rOutData/rOutValid come from the last stage.
- Each stage i holds a valid bit v[i] and a data register d[i].
- Advance rule: stage i loads when v[i]==0 or stage i drains this cycle. The last stage drains when rOutValid && wOutReady.
- rInReady = !v[1] || stage 1 drains; it is combinational from wOutReady through the chain.
- Input handshake: wInValid && rInReady. On handshake, stage 1 loads on the next edge. Stage 1 does not load when there is no handshake.
- Latency: STAGES cycles from input handshake to rOutValid, with no backpressure. Throughput is 1 word/cycle while wOutReady is held high.
- Backpressure: data stalls in place and nothing is dropped or duplicated. Up to STAGES words are buffered. Once all stages are full and wOutReady=0, rInReady=0.
- While rOutValid=1 and wOutReady=0, rOutData must stay stable.
- Simultaneous input and output handshake on a full pipe: both occur, and occupancy is unchanged.
- rXferCount increments by 1 per output handshake. It wraps from 2^CNT_W-1 to 0.
- Reset, asynchronous and applicable at any time:
  - All v[i]=0, all d[i]=0, rOutValid=0, rOutData=0, rXferCount=0.
  - rInReady=1 combinationally once reset deasserts.
  - In-flight words are discarded.
- wInData, wSubKey and wXorEn are don't-care when wInValid=0.

Test Plan:
- FIPS vector, GROUPS=8, STAGES=2, wXorEn=0, wInData=0xF0AAF0AA, wOutReady=1 -> rOutValid rises 2 cycles after the handshake, rOutData=0x7A15557A1555, rXferCount=1.
- Same input with wXorEn=1, wSubKey=0x1B02EFFC7072 -> rOutData=0x6117BA866527.
- Wrap bits: wInData=0x80000001, wXorEn=0 -> rOutData=0xC0000000000 3 pattern; checker confirms E[1]=in[32]=1, E[48]=in[1]=1, E[2]=1, E[47]=1, i.e. 0xC00000000003.
- Backpressure, STAGES=2: stream 5 words with wOutReady=0 -> rInReady drops after 2 accepts and rOutData is stable. Release wOutReady -> all 5 words emerge in order with no loss, and rXferCount=5.
- Full-throughput stream of 100 random words with a reference model and random wXorEn -> 100 in-order matches. Toggling wOutReady randomly causes no loss and no duplication.
- Reset mid-stream with 2 words in flight -> rOutValid=0, rOutData=0 and rXferCount=0 immediately. The first post-reset word is the next output, with latency STAGES.
- Counter wrap, CNT_W=4: 17 transfers -> rXferCount=1.
